// File: rtl/hw_barrier_array.sv
// Multi-barrier unit: NB_BARR independent team barriers with register-bus configuration.
// Optional per-barrier timeout enabled by defining HW_BARR_TIMEOUT_EN.
module hw_barrier_array #(
    parameter int NB_CORES     = 8,
    parameter int NB_BARR      = 8,
    parameter int GEN_W        = 8,
    parameter int TIMEOUT_W    = 16,
    parameter int PER_ID_WIDTH = 9,
    parameter int ADDR_W       = $clog2(NB_BARR) + 5
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NB_CORES-1:0][NB_BARR-1:0]       barrier_trigger_core_i,
    output logic [NB_BARR-1:0][NB_CORES-1:0]       barrier_events_o,
    output logic [NB_BARR-1:0]                     barrier_timeout_o,
    input  logic                                   cfg_req_i,
    input  logic [ADDR_W-1:0]                      cfg_add_i,
    input  logic                                   cfg_wen_i,
    input  logic [31:0]                            cfg_wdata_i,
    input  logic [PER_ID_WIDTH-1:0]                cfg_id_i,
    output logic                                   cfg_gnt_o,
    output logic                                   cfg_r_valid_o,
    output logic [31:0]                            cfg_r_rdata_o,
    output logic                                   cfg_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]                cfg_r_id_o
);

    localparam logic [2:0] OFF_TEAM    = 3'd0;
    localparam logic [2:0] OFF_TARGET  = 3'd1;
    localparam logic [2:0] OFF_STATUS  = 3'd2;
    localparam logic [2:0] OFF_GEN     = 3'd3;
    localparam logic [2:0] OFF_TIMEOUT = 3'd4;

    logic [ADDR_W-1:0] w_idx;
    logic [2:0]        w_off;
    logic              w_idx_ok;
    logic              w_wr;
    logic              w_unused_bits;

    assign w_idx         = cfg_add_i >> 5;
    assign w_off         = cfg_add_i[4:2];
    assign w_idx_ok      = (w_idx < ADDR_W'(NB_BARR));
    assign w_wr          = cfg_req_i && !cfg_wen_i && w_idx_ok;
    assign w_unused_bits = ^{cfg_add_i[1:0], cfg_wdata_i};
    assign cfg_gnt_o     = cfg_req_i;

    logic [NB_BARR-1:0][NB_CORES-1:0] w_team;
    logic [NB_BARR-1:0][NB_CORES-1:0] w_target;
    logic [NB_BARR-1:0][NB_CORES-1:0] w_status;
    logic [NB_BARR-1:0][GEN_W-1:0]    w_gen;
    logic [NB_BARR-1:0][31:0]         w_tmo_rd;

    genvar gi, gc;
    generate
        for (gi = 0; gi < NB_BARR; gi++) begin : g_barr
            logic [NB_CORES-1:0] r_team, r_target, r_status, r_events;
            logic [GEN_W-1:0]    r_gen;
            logic [NB_CORES-1:0] w_trig, w_status_next;
            logic                w_sel, w_team_wr, w_target_wr, w_complete, w_expire;

            for (gc = 0; gc < NB_CORES; gc++) begin : g_trig
                assign w_trig[gc] = barrier_trigger_core_i[gc][gi];
            end

            assign w_sel         = w_wr && (w_idx == ADDR_W'(gi));
            assign w_team_wr     = w_sel && (w_off == OFF_TEAM);
            assign w_target_wr   = w_sel && (w_off == OFF_TARGET);
            assign w_status_next = r_status | (w_trig & r_team);
            // A TEAM write in the same cycle discards any arrivals for this barrier.
            assign w_complete    = !w_team_wr && (r_team != '0) && (w_status_next == r_team);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_team   <= '0;
                    r_target <= '0;
                    r_status <= '0;
                    r_gen    <= '0;
                    r_events <= '0;
                end else begin
                    if (w_team_wr)
                        r_team <= cfg_wdata_i[NB_CORES-1:0];
                    if (w_target_wr)
                        r_target <= cfg_wdata_i[NB_CORES-1:0];
                    if (w_team_wr || w_complete || w_expire)
                        r_status <= '0;
                    else
                        r_status <= w_status_next;
                    if (w_complete)
                        r_gen <= r_gen + GEN_W'(1);
                    r_events <= w_complete ? r_target : '0;
                end
            end

`ifdef HW_BARR_TIMEOUT_EN
            logic [TIMEOUT_W-1:0] r_tmo, r_cnt;
            logic                 r_tout;

            // Counter sits at 0 while idle, so the first arrival starts it from 0.
            assign w_expire = !w_team_wr && !w_complete && (r_status != '0) &&
                              (r_tmo != '0) && ((r_cnt + TIMEOUT_W'(1)) == r_tmo);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_tmo  <= '0;
                    r_cnt  <= '0;
                    r_tout <= 1'b0;
                end else begin
                    if (w_sel && (w_off == OFF_TIMEOUT))
                        r_tmo <= cfg_wdata_i[TIMEOUT_W-1:0];
                    if (w_team_wr || w_complete || w_expire || (r_status == '0))
                        r_cnt <= '0;
                    else
                        r_cnt <= r_cnt + TIMEOUT_W'(1);
                    r_tout <= w_expire;
                end
            end

            assign w_tmo_rd[gi]          = 32'(r_tmo);
            assign barrier_timeout_o[gi] = r_tout;
`else
            logic [TIMEOUT_W-1:0] w_unused_tmo;
            assign w_unused_tmo          = '0;
            assign w_expire              = 1'b0;
            assign w_tmo_rd[gi]          = '0;
            assign barrier_timeout_o[gi] = 1'b0;
`endif

            assign w_team[gi]           = r_team;
            assign w_target[gi]         = r_target;
            assign w_status[gi]         = r_status;
            assign w_gen[gi]            = r_gen;
            assign barrier_events_o[gi] = r_events;
        end
    endgenerate

    logic [31:0] w_rd_data;

    always_comb begin
        w_rd_data = '0;
        for (int b = 0; b < NB_BARR; b++) begin
            if (w_idx == ADDR_W'(b)) begin
                case (w_off)
                    OFF_TEAM:    w_rd_data = 32'(w_team[b]);
                    OFF_TARGET:  w_rd_data = 32'(w_target[b]);
                    OFF_STATUS:  w_rd_data = 32'(w_status[b]);
                    OFF_GEN:     w_rd_data = 32'(w_gen[b]);
                    OFF_TIMEOUT: w_rd_data = w_tmo_rd[b];
                    default:     w_rd_data = '0;
                endcase
            end
        end
    end

    logic                    r_rvalid, r_opc;
    logic [31:0]             r_rdata;
    logic [PER_ID_WIDTH-1:0] r_rid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_opc    <= 1'b0;
            r_rid    <= '0;
        end else begin
            r_rvalid <= cfg_req_i;
            r_rdata  <= (cfg_req_i && cfg_wen_i) ? w_rd_data : '0;
            r_opc    <= cfg_req_i && !w_idx_ok;
            if (cfg_req_i)
                r_rid <= cfg_id_i;
        end
    end

    assign cfg_r_valid_o = r_rvalid;
    assign cfg_r_rdata_o = r_rdata;
    assign cfg_r_opc_o   = r_opc;
    assign cfg_r_id_o    = r_rid;

endmodule

// File: tb/tb_hw_barrier_array.sv
// Directed bench for hw_barrier_array (6 barriers so an out-of-range index is addressable).
module tb_hw_barrier_array;
    localparam int NC  = 8;
    localparam int NB  = 6;
    localparam int GW  = 8;
    localparam int TW  = 16;
    localparam int IDW = 9;
    localparam int AW  = $clog2(NB) + 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0][NB-1:0] trig;
    logic [NB-1:0][NC-1:0] events;
    logic [NB-1:0]         tout;
    logic                  req, wen, gnt, rvalid, opc;
    logic [AW-1:0]         add;
    logic [31:0]           wdata, rdata;
    logic [IDW-1:0]        id, rid;

    int checks = 0;
    int errors = 0;

    hw_barrier_array #(
        .NB_CORES(NC), .NB_BARR(NB), .GEN_W(GW), .TIMEOUT_W(TW),
        .PER_ID_WIDTH(IDW), .ADDR_W(AW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .barrier_trigger_core_i(trig), .barrier_events_o(events), .barrier_timeout_o(tout),
        .cfg_req_i(req), .cfg_add_i(add), .cfg_wen_i(wen), .cfg_wdata_i(wdata), .cfg_id_i(id),
        .cfg_gnt_o(gnt), .cfg_r_valid_o(rvalid), .cfg_r_rdata_o(rdata),
        .cfg_r_opc_o(opc), .cfg_r_id_o(rid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int b, input int off, input logic [31:0] d);
        req = 1'b1; wen = 1'b0; add = AW'(b * 32 + off); wdata = d; id = '0;
        tick();
        req = 1'b0; wen = 1'b1;
        $display("bus wr b=%0d off=0x%02h data=0x%08h opc=%0b", b, off, d, opc);
    endtask

    task automatic bus_read(input int b, input int off, input logic [IDW-1:0] tid,
                            output logic [31:0] rd, output logic o,
                            output logic [IDW-1:0] ri, output logic v);
        req = 1'b1; wen = 1'b1; add = AW'(b * 32 + off); id = tid;
        tick();
        req = 1'b0;
        rd = rdata; o = opc; ri = rid; v = rvalid;
        $display("bus rd b=%0d off=0x%02h id=0x%03h data=0x%08h opc=%0b", b, off, tid, rd, o);
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic o, v; logic [IDW-1:0] ri;
        repeat (2) tick();
        checks++; if (events !== '0) begin errors++; $display("FAIL reset_events: got %h expected 0", events); end
        checks++; if (tout !== '0) begin errors++; $display("FAIL reset_timeout: got %h expected 0", tout); end
        checks++; if ({rvalid, rdata, opc, rid} !== '0) begin errors++;
            $display("FAIL reset_resp: got v=%b d=%h o=%b id=%h expected all 0", rvalid, rdata, opc, rid); end
        req = 1'b1; #1;
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL gnt_high: got %b expected 1", gnt); end
        req = 1'b0; #1;
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL gnt_low: got %b expected 0", gnt); end
        rst_n = 1'b1;
        tick();
        bus_read(0, 'h0C, 9'h055, rd, o, ri, v);
        checks++; if ({v, rd, o, ri} !== {1'b1, 32'h0, 1'b0, 9'h055}) begin errors++;
            $display("FAIL reset_gen_read: got v=%b d=%h o=%b id=%h expected v=1 d=0 o=0 id=055", v, rd, o, ri); end
    endtask

    task automatic test_basic;
        logic [31:0] rd; logic o, v; logic [IDW-1:0] ri;
        logic [NB-1:0][NC-1:0] exp_ev;
        bus_write(0, 'h00, 32'h0F);
        bus_write(0, 'h04, 32'hFF);
        trig[0][0] = 1'b1; tick(); trig = '0;
        checks++; if (events !== '0) begin errors++; $display("FAIL basic_early1: got %h expected 0", events); end
        tick();
        trig[1][0] = 1'b1; trig[2][0] = 1'b1; tick(); trig = '0;
        checks++; if (events !== '0) begin errors++; $display("FAIL basic_early2: got %h expected 0", events); end
        tick(); tick();
        trig[3][0] = 1'b1; tick(); trig = '0;
        exp_ev = '0; exp_ev[0] = 8'hFF;
        checks++; if (events !== exp_ev) begin errors++; $display("FAIL basic_release: got %h expected %h", events, exp_ev); end
        tick();
        checks++; if (events !== '0) begin errors++; $display("FAIL basic_one_cycle: got %h expected 0", events); end
        bus_read(0, 'h0C, 9'h001, rd, o, ri, v);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL basic_gen: got %h expected 1", rd); end
        bus_read(0, 'h08, 9'h002, rd, o, ri, v);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL basic_status: got %h expected 0", rd); end
    endtask

    task automatic test_mask;
        logic [31:0] rd; logic o, v; logic [IDW-1:0] ri;
        logic [NB-1:0][NC-1:0] exp_ev;
        bus_write(0, 'h00, 32'h03);
        trig[5][0] = 1'b1;
        for (int c = 0; c < NC; c++) trig[c][1] = 1'b1;
        tick(); trig = '0;
        checks++; if (events !== '0) begin errors++; $display("FAIL mask_nonteam: got %h expected 0", events); end
        bus_read(0, 'h08, 9'h003, rd, o, ri, v);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mask_status0: got %h expected 0", rd); end
        trig[0][0] = 1'b1; trig[0][1] = 1'b1; tick(); trig = '0;
        bus_read(0, 'h08, 9'h004, rd, o, ri, v);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mask_status1: got %h expected 1", rd); end
        trig[1][0] = 1'b1; trig[1][1] = 1'b1; tick(); trig = '0;
        exp_ev = '0; exp_ev[0] = 8'hFF;
        checks++; if (events !== exp_ev) begin errors++; $display("FAIL mask_release: got %h expected %h", events, exp_ev); end
        bus_read(0, 'h0C, 9'h005, rd, o, ri, v);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL mask_gen: got %h expected 2", rd); end
    endtask

    task automatic test_abort;
        logic [31:0] rd; logic o, v; logic [IDW-1:0] ri;
        bus_write(0, 'h00, 32'h0F);
        trig[0][0] = 1'b1; trig[1][0] = 1'b1; trig[2][0] = 1'b1; tick(); trig = '0;
        bus_read(0, 'h08, 9'h006, rd, o, ri, v);
        checks++; if (rd !== 32'h07) begin errors++; $display("FAIL abort_status7: got %h expected 07", rd); end
        req = 1'b1; wen = 1'b0; add = AW'(0); wdata = 32'h0F; trig[3][0] = 1'b1;
        tick();
        req = 1'b0; wen = 1'b1; trig = '0;
        checks++; if (events !== '0) begin errors++; $display("FAIL abort_no_release: got %h expected 0", events); end
        tick();
        checks++; if (events !== '0) begin errors++; $display("FAIL abort_no_late: got %h expected 0", events); end
        bus_read(0, 'h08, 9'h007, rd, o, ri, v);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_status: got %h expected 0", rd); end
        bus_read(0, 'h0C, 9'h008, rd, o, ri, v);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL abort_gen: got %h expected 2", rd); end
    endtask

    task automatic test_target_same_cycle;
        logic [31:0] rd; logic o, v; logic [IDW-1:0] ri;
        bus_write(0, 'h00, 32'h01);
        req = 1'b1; wen = 1'b0; add = AW'(4); wdata = 32'h0A; trig[0][0] = 1'b1;
        tick();
        req = 1'b0; wen = 1'b1; trig = '0;
        checks++; if (events[0] !== 8'hFF) begin errors++; $display("FAIL target_old: got %h expected ff", events[0]); end
        trig[0][0] = 1'b1; tick(); trig = '0;
        checks++; if (events[0] !== 8'h0A) begin errors++; $display("FAIL target_new: got %h expected 0a", events[0]); end
        bus_read(0, 'h0C, 9'h009, rd, o, ri, v);
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL target_gen: got %h expected 4", rd); end
    endtask

    task automatic test_parallel;
        logic [NB-1:0][NC-1:0] exp_ev;
        bus_write(2, 'h00, 32'h01);
        bus_write(2, 'h04, 32'h10);
        bus_write(3, 'h00, 32'h02);
        bus_write(3, 'h04, 32'h20);
        trig[0][2] = 1'b1; trig[1][3] = 1'b1; tick(); trig = '0;
        exp_ev = '0; exp_ev[2] = 8'h10; exp_ev[3] = 8'h20;
        checks++; if (events !== exp_ev) begin errors++; $display("FAIL parallel_release: got %h expected %h", events, exp_ev); end
    endtask

    task automatic test_gen_wrap;
        logic [31:0] rd; logic o, v; logic [IDW-1:0] ri;
        bus_write(4, 'h00, 32'h01);
        trig[0][4] = 1'b1;
        repeat (255) tick();
        trig = '0;
        bus_read(4, 'h0C, 9'h00A, rd, o, ri, v);
        checks++; if (rd !== 32'd255) begin errors++; $display("FAIL gen_255: got %h expected ff", rd); end
        trig[0][4] = 1'b1; tick(); trig = '0;
        bus_read(4, 'h0C, 9'h00B, rd, o, ri, v);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL gen_wrap: got %h expected 0", rd); end
    endtask

    task automatic test_bus_corner;
        logic [31:0] rd; logic o, v; logic [IDW-1:0] ri;
        logic [31:0] exp_tmo;
        bus_write(0, 'h00, 32'h0F);
        trig[0][0] = 1'b1; tick(); trig = '0;
        bus_write(0, 'h08, 32'hFF);
        checks++; if ({rvalid, opc} !== 2'b10) begin errors++; $display("FAIL ro_write_opc: got v=%b o=%b expected v=1 o=0", rvalid, opc); end
        bus_read(0, 'h08, 9'h00C, rd, o, ri, v);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL ro_write_ignored: got %h expected 01", rd); end
        bus_read(NB, 'h00, 9'h1A5, rd, o, ri, v);
        checks++; if ({v, rd, o, ri} !== {1'b1, 32'h0, 1'b1, 9'h1A5}) begin errors++;
            $display("FAIL oob_read: got v=%b d=%h o=%b id=%h expected v=1 d=0 o=1 id=1a5", v, rd, o, ri); end
        bus_write(NB, 'h00, 32'hFF);
        checks++; if (opc !== 1'b1) begin errors++; $display("FAIL oob_write_opc: got %b expected 1", opc); end
        bus_read(0, 'h14, 9'h00D, rd, o, ri, v);
        checks++; if ({rd, o} !== {32'h0, 1'b0}) begin errors++; $display("FAIL reserved_read: got d=%h o=%b expected d=0 o=0", rd, o); end
        bus_write(1, 'h10, 32'd20);
`ifdef HW_BARR_TIMEOUT_EN
        exp_tmo = 32'd20;
`else
        exp_tmo = 32'd0;
`endif
        bus_read(1, 'h10, 9'h00E, rd, o, ri, v);
        checks++; if (rd !== exp_tmo) begin errors++; $display("FAIL timeout_reg: got %h expected %h", rd, exp_tmo); end
    endtask

    task automatic test_back_to_back;
        req = 1'b1; wen = 1'b0; add = AW'(5 * 32 + 4); wdata = 32'h33; id = 9'h011;
        tick();
        $display("bus wr b=5 off=0x04 data=0x00000033 (back-to-back)");
        checks++; if ({rvalid, rid} !== {1'b1, 9'h011}) begin errors++; $display("FAIL b2b_wr_resp: got v=%b id=%h expected v=1 id=011", rvalid, rid); end
        wen = 1'b1; id = 9'h022;
        tick();
        req = 1'b0;
        $display("bus rd b=5 off=0x04 id=0x022 data=0x%08h (back-to-back)", rdata);
        checks++; if ({rvalid, rid, rdata} !== {1'b1, 9'h022, 32'h33}) begin errors++;
            $display("FAIL b2b_rd_resp: got v=%b id=%h d=%h expected v=1 id=022 d=33", rvalid, rid, rdata); end
        tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", rvalid); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic o, v; logic [IDW-1:0] ri;
        bus_write(5, 'h00, 32'h03);
        trig[0][5] = 1'b1; tick(); trig = '0;
        trig[1][5] = 1'b1;
        #2 rst_n = 1'b0;
        #1 trig = '0;
        checks++; if (events !== '0) begin errors++; $display("FAIL rstmid_async: got %h expected 0", events); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (events !== '0) begin errors++; $display("FAIL rstmid_no_event: got %h expected 0", events); end
        bus_read(5, 'h00, 9'h00F, rd, o, ri, v);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_team: got %h expected 0", rd); end
        bus_read(5, 'h04, 9'h010, rd, o, ri, v);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_target: got %h expected 0", rd); end
    endtask

`ifdef HW_BARR_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] rd; logic o, v; logic [IDW-1:0] ri;
        logic [NB-1:0] exp_t;
        bus_write(0, 'h00, 32'h03);
        bus_write(0, 'h04, 32'h0C);
        bus_write(0, 'h10, 32'd20);
        trig[0][0] = 1'b1; tick(); trig = '0;
        for (int c = 1; c <= 22; c++) begin
            exp_t = (c == 21) ? NB'(1) : '0;
            checks++; if (tout !== exp_t) begin errors++; $display("FAIL timeout_c%0d: got %h expected %h", c, tout, exp_t); end
            tick();
        end
        bus_read(0, 'h08, 9'h012, rd, o, ri, v);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL timeout_status: got %h expected 0", rd); end
        trig[0][0] = 1'b1; tick(); trig = '0;
        for (int c = 1; c < 20; c++) tick();
        trig[1][0] = 1'b1; tick(); trig = '0;
        checks++; if ({events[0], tout} !== {8'h0C, NB'(0)}) begin errors++;
            $display("FAIL timeout_vs_release: got ev=%h to=%h expected ev=0c to=0", events[0], tout); end
        tick();
        checks++; if (tout !== '0) begin errors++; $display("FAIL timeout_after_release: got %h expected 0", tout); end
    endtask
`endif

    initial begin
        trig = '0; req = 1'b0; wen = 1'b1; add = '0; wdata = '0; id = '0;
        test_reset();
        test_basic();
        test_mask();
        test_abort();
        test_target_same_cycle();
        test_parallel();
        test_gen_wrap();
        test_bus_corner();
        test_back_to_back();
        test_reset_mid();
`ifdef HW_BARR_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
